plus_collector: RTL and testbench



---
 rtl/plus_pkg.sv | 18 +
 rtl/plus_collector.sv | 87 ++++++++
 tb/tb_plus_collector.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/plus_pkg.sv
// Shared types and widths for the summing-module capture path.
package plus_pkg;

  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;
  localparam int PLUS_W = 32;

  localparam logic [PLUS_W-1:0] PLUS_EXPECT = 32'd15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PULSE    = 3'd1,
    SETTLE_W = 3'd2,
    CAPTURE  = 3'd3,
    RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/plus_collector.sv
// Pulses the summing module a requested number of times, accumulates and
// checks each out_plus sample, and returns the total on a valid/ready channel.
//
// state    | meaning
// IDLE     | ready for a request
// PULSE    | io_start high for one cycle
// SETTLE_W | waiting SETTLE cycles for the upstream sum to settle
// CAPTURE  | add sample to acc, flag mismatch, count down remaining
// RESP     | response held until io_resp_ready
module plus_collector
  import plus_pkg::*;
#(
  parameter int unsigned       SETTLE = 0,
  parameter logic [PLUS_W-1:0] EXPECT = PLUS_EXPECT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [CNT_W-1:0]  io_req_count,
  output logic              io_start,
  input  logic [PLUS_W-1:0] io_in_plus,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [ACC_W-1:0]  io_resp_sum,
  output logic              io_resp_err
);

  // SETTLE is limited to 0..15 so it fits the 4-bit wait counter.
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [3:0]         wait_cnt;
  logic [ACC_W-1:0]   acc;
  logic               err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      wait_cnt  <= '0;
      acc       <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (io_req_valid) begin
            remaining <= io_req_count;
            acc       <= '0;
            err       <= 1'b0;
          end
        end
        PULSE:    wait_cnt <= SETTLE_L;
        SETTLE_W: wait_cnt <= wait_cnt - 4'd1;
        CAPTURE: begin
          acc       <= acc + ACC_W'(io_in_plus);
          remaining <= remaining - CNT_W'(1);
          if (io_in_plus != EXPECT) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (io_req_valid) state_nxt = (io_req_count == '0) ? RESP : PULSE;
      PULSE:    state_nxt = (SETTLE_L != 4'd0) ? SETTLE_W : CAPTURE;
      SETTLE_W: if (wait_cnt == 4'd1) state_nxt = CAPTURE;
      CAPTURE:  state_nxt = (remaining == CNT_W'(1)) ? RESP : PULSE;
      RESP:     if (io_resp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Every output is a pure decode of registered state.
  assign io_req_ready  = (state == IDLE);
  assign io_start      = (state == PULSE);
  assign io_resp_valid = (state == RESP);
  assign io_resp_sum   = (state == RESP) ? acc : '0;
  assign io_resp_err   = (state == RESP) ? err : 1'b0;

endmodule

// File: tb/tb_plus_collector.sv
// Bench for plus_collector: two instances (SETTLE 0 and 3) driven by a
// behavioural stand-in for the upstream summing module.
module tb_plus_collector;
  import plus_pkg::*;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [CNT_W-1:0]  req_count [2];
  logic [1:0]        start;
  logic [PLUS_W-1:0] plus_reg [2];
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [ACC_W-1:0]  resp_sum [2];
  logic [1:0]        resp_err;

  int checks = 0;
  int errors = 0;

  // Upstream stand-in: every start pulse loads a new sample, recorded in given_q.
  logic [PLUS_W-1:0] given_q [$];
  int                stub_base = 0;
  int                stub_bad_idx = 0;
  logic [PLUS_W-1:0] stub_bad_val = '0;
  bit                stub_rnd = 0;
  logic [PLUS_W-1:0] stub_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  plus_collector #(.SETTLE(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .io_req_valid(req_valid[0]), .io_req_ready(req_ready[0]), .io_req_count(req_count[0]),
    .io_start(start[0]), .io_in_plus(plus_reg[0]),
    .io_resp_valid(resp_valid[0]), .io_resp_ready(resp_ready[0]),
    .io_resp_sum(resp_sum[0]), .io_resp_err(resp_err[0])
  );

  plus_collector #(.SETTLE(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .io_req_valid(req_valid[1]), .io_req_ready(req_ready[1]), .io_req_count(req_count[1]),
    .io_start(start[1]), .io_in_plus(plus_reg[1]),
    .io_resp_valid(resp_valid[1]), .io_resp_ready(resp_ready[1]),
    .io_resp_sum(resp_sum[1]), .io_resp_err(resp_err[1])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (start[i]) begin
        if (stub_rnd)
          stub_v = ($urandom_range(0, 3) == 0) ? $urandom : 32'd15;
        else
          stub_v = ((given_q.size() - stub_base + 1) == stub_bad_idx) ? stub_bad_val : 32'd15;
        given_q.push_back(stub_v);
        plus_reg[i] <= stub_v;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One request/response on instance sel. With use_exp the table values are
  // required, otherwise the sum/err come from the recorded samples.
  task automatic run_txn(input int sel, input int cnt, input int bad_idx,
                         input logic [31:0] bad_val, input bit rnd, input int hold,
                         input bit use_exp, input logic [39:0] exp_sum_t,
                         input bit exp_err_t, input int exp_lat_t);
    int s, k, lat, bad_pulse, bad_zero, bad_hold, n_samp;
    bit got, exp_start;
    logic [63:0] msum;
    bit merr;
    logic [39:0] held_sum;
    bit held_err;
    s = (sel == 1) ? 3 : 0;
    k = 0; lat = -1; got = 0; bad_pulse = 0; bad_zero = 0; bad_hold = 0;
    @(negedge clk);
    stub_base = given_q.size();
    stub_bad_idx = bad_idx;
    stub_bad_val = bad_val;
    stub_rnd = rnd;
    check("req_ready_before", {63'd0, req_ready[sel]}, 64'd1);
    req_valid[sel] = 1'b1;
    req_count[sel] = CNT_W'(cnt);
    resp_ready[sel] = (hold == 0);
    while (!got && k < 2000) begin
      @(negedge clk);
      k++;
      req_valid[sel] = 1'b0;
      if (resp_valid[sel]) begin
        got = 1;
        lat = k;
      end else begin
        if (resp_sum[sel] != '0 || resp_err[sel]) bad_zero++;
        exp_start = ((k - 1) % (2 + s) == 0) && ((k - 1) / (2 + s) < cnt);
        if (start[sel] != exp_start) bad_pulse++;
      end
    end
    check("resp_seen", {63'd0, got}, 64'd1);
    check("latency", 64'(lat), use_exp ? 64'(exp_lat_t) : 64'(cnt * (2 + s) + 1));
    check("pulse_timing", 64'(bad_pulse), 64'd0);
    check("zero_outside_resp", 64'(bad_zero), 64'd0);
    n_samp = given_q.size() - stub_base;
    check("sample_count", 64'(n_samp), 64'(cnt));
    msum = '0;
    merr = 0;
    for (int i = stub_base; i < given_q.size(); i++) begin
      msum += 64'(given_q[i]);
      if (given_q[i] != 32'd15) merr = 1;
    end
    check("resp_sum", 64'(resp_sum[sel]), use_exp ? 64'(exp_sum_t) : msum);
    check("resp_err", {63'd0, resp_err[sel]}, use_exp ? {63'd0, exp_err_t} : {63'd0, merr});
    held_sum = resp_sum[sel];
    held_err = resp_err[sel];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!resp_valid[sel] || resp_sum[sel] != held_sum || resp_err[sel] != held_err) bad_hold++;
    end
    if (hold > 0) check("resp_held_stable", 64'(bad_hold), 64'd0);
    resp_ready[sel] = 1'b1;
    @(negedge clk);
    check("idle_after_handshake", {62'd0, req_ready[sel], resp_valid[sel]}, 64'd2);
  endtask

  typedef struct {
    int          sel;
    int          cnt;
    int          bad_idx;
    logic [31:0] bad_val;
    int          hold;
    logic [39:0] exp_sum;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];
  int   bad_idle;

  initial begin
    vecs[0] = '{sel: 0, cnt: 4,   bad_idx: 0, bad_val: 32'd0,  hold: 0,  exp_sum: 40'd60,   exp_err: 1'b0, exp_lat: 9};
    vecs[1] = '{sel: 0, cnt: 0,   bad_idx: 0, bad_val: 32'd0,  hold: 0,  exp_sum: 40'd0,    exp_err: 1'b0, exp_lat: 1};
    vecs[2] = '{sel: 0, cnt: 255, bad_idx: 0, bad_val: 32'd0,  hold: 0,  exp_sum: 40'hEF1,  exp_err: 1'b0, exp_lat: 511};
    vecs[3] = '{sel: 1, cnt: 2,   bad_idx: 0, bad_val: 32'd0,  hold: 0,  exp_sum: 40'd30,   exp_err: 1'b0, exp_lat: 11};
    vecs[4] = '{sel: 0, cnt: 3,   bad_idx: 2, bad_val: 32'd14, hold: 10, exp_sum: 40'd44,   exp_err: 1'b1, exp_lat: 7};

    reset = 1'b1;
    req_valid = '0;
    resp_ready = '1;
    req_count[0] = '0;
    req_count[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_outputs", {57'd0, req_ready[i], start[i], resp_valid[i], resp_err[i], 3'd0},
            {57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
      check("reset_sum", 64'(resp_sum[i]), 64'd0);
    end
    reset = 1'b0;

    for (int v = 0; v < 5; v++)
      run_txn(vecs[v].sel, vecs[v].cnt, vecs[v].bad_idx, vecs[v].bad_val, 1'b0,
              vecs[v].hold, 1'b1, vecs[v].exp_sum, vecs[v].exp_err, vecs[v].exp_lat);

    // Reset in cycle 4 of a count=10 request on the SETTLE=0 instance.
    @(negedge clk);
    stub_rnd = 0;
    stub_bad_idx = 0;
    req_valid[0] = 1'b1;
    req_count[0] = 8'd10;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_outputs", {60'd0, req_ready[0], start[0], resp_valid[0], resp_err[0]},
          {60'd0, 4'b1000});
    check("midreset_sum", 64'(resp_sum[0]), 64'd0);
    bad_idle = 0;
    repeat (6) begin
      @(negedge clk);
      if (start[0] || resp_valid[0] || !req_ready[0]) bad_idle++;
    end
    check("no_response_after_reset", 64'(bad_idle), 64'd0);
    run_txn(0, 1, 0, 32'd0, 1'b0, 0, 1'b1, 40'd15, 1'b0, 3);

    for (int r = 0; r < 25; r++)
      run_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)), 0, 32'd0, 1'b1,
              int'($urandom_range(0, 3)), 1'b0, 40'd0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
